// File: rtl/muller_c_pkg.sv
// Shared types and constants for the Muller C-element bank.
// Holds the completion-mode encoding and the disagree-counter width.
package muller_c_pkg;

    typedef enum logic [1:0] {
        MODE_SYM  = 2'd0,
        MODE_MAJ  = 2'd1,
        MODE_ASYM = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam int DIS_W = 16;

endpackage

// File: rtl/muller_c_cell.sv
// One sampled C-element channel: synchroniser, mode evaluation, output
// register, saturating toggle counter and disagreement watchdog.
// Ports: clk, rst_n (sync, active-low), in_bits[INPUTS], mode[2],
//        clr_cnt, c_out, toggles[CNT_W], stuck.
module muller_c_cell
    import muller_c_pkg::*;
#(
    parameter int INPUTS      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16,
    parameter bit INIT        = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] in_bits,
    input  logic [1:0]        mode,
    input  logic              clr_cnt,
    output logic              c_out,
    output logic [CNT_W-1:0]  toggles,
    output logic              stuck
);

    localparam logic [3:0] N_IN = 4'(INPUTS);
    localparam logic [3:0] HALF = 4'(INPUTS / 2);
    localparam logic [DIS_W-1:0] LIMIT = DIS_W'(TIMEOUT);

    logic [INPUTS-1:0] s;
    logic [3:0]        ones;
    logic [3:0]        zeros;
    logic              all1;
    logic              all0;
    logic              c_next;
    logic [DIS_W-1:0]  dis_cnt;
    mode_t             m;

    // Synchroniser; flops reset to INIT so c_out does not move on release
    // until real input data has propagated through.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = in_bits;
    end else begin : g_sync
        logic [INPUTS-1:0] sync_q [SYNC_STAGES];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++)
                    sync_q[i] <= {INPUTS{INIT}};
            end else begin
                sync_q[0] <= in_bits;
                for (int i = 1; i < SYNC_STAGES; i++)
                    sync_q[i] <= sync_q[i-1];
            end
        end
        assign s = sync_q[SYNC_STAGES-1];
    end

    assign m    = mode_t'(mode);
    assign all1 = &s;
    assign all0 = ~|s;

    always_comb begin
        ones = '0;
        for (int i = 0; i < INPUTS; i++)
            ones = ones + 4'(s[i]);
        zeros = N_IN - ones;
    end

    // Next output: each mode only ever sets or resets; otherwise hold.
    always_comb begin
        c_next = c_out;
        unique case (m)
            MODE_MAJ: begin
                if (ones > HALF)
                    c_next = 1'b1;
                else if (zeros > HALF)
                    c_next = 1'b0;
            end
            MODE_ASYM: begin
                if (all1)
                    c_next = 1'b1;
                else if (!s[0])
                    c_next = 1'b0;
            end
            MODE_SYM, MODE_RSVD: begin
                if (all1)
                    c_next = 1'b1;
                else if (all0)
                    c_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_out   <= INIT;
            toggles <= '0;
            dis_cnt <= '0;
        end else begin
            c_out <= c_next;

            // Clear has priority over a same-cycle toggle.
            if (clr_cnt)
                toggles <= '0;
            else if (c_next != c_out && toggles != '1)
                toggles <= toggles + 1'b1;

            if (clr_cnt || all1 || all0)
                dis_cnt <= '0;
            else if (dis_cnt != '1)
                dis_cnt <= dis_cnt + 1'b1;
        end
    end

    assign stuck = (dis_cnt >= LIMIT);

endmodule

// File: rtl/muller_c_bank.sv
// Bank of CHANNELS independent sampled Muller C-elements.
// Ports: clk, rst_n, in_vec[CHANNELS*INPUTS], mode[2], clr_cnt,
//        c_out[CHANNELS], toggles[CHANNELS*CNT_W], stuck[CHANNELS].
module muller_c_bank
    import muller_c_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int INPUTS      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16,
    parameter bit INIT        = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*INPUTS-1:0] in_vec,
    input  logic [1:0]                mode,
    input  logic                      clr_cnt,
    output logic [CHANNELS-1:0]       c_out,
    output logic [CHANNELS*CNT_W-1:0] toggles,
    output logic [CHANNELS-1:0]       stuck
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        muller_c_cell #(
            .INPUTS      (INPUTS),
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .TIMEOUT     (TIMEOUT),
            .INIT        (INIT)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_bits (in_vec[ch*INPUTS +: INPUTS]),
            .mode    (mode),
            .clr_cnt (clr_cnt),
            .c_out   (c_out[ch]),
            .toggles (toggles[ch*CNT_W +: CNT_W]),
            .stuck   (stuck[ch])
        );
    end

endmodule

// File: tb/tb_muller_c_bank.sv
// Directed bench for muller_c_bank.
// Two instances: 3-input bank (INIT=1, CNT_W=2, TIMEOUT=4) and 4-input bank.
module tb_muller_c_bank;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        clr_cnt;

    logic [11:0] in_a;
    logic [3:0]  c_out_a;
    logic [7:0]  toggles_a;
    logic [3:0]  stuck_a;

    logic [15:0] in_b;
    logic [3:0]  c_out_b;
    logic [31:0] toggles_b;
    logic [3:0]  stuck_b;

    int n_vec = 0;
    int n_err = 0;

    muller_c_bank #(
        .CHANNELS    (4),
        .INPUTS      (3),
        .SYNC_STAGES (2),
        .CNT_W       (2),
        .TIMEOUT     (4),
        .INIT        (1'b1)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vec  (in_a),
        .mode    (mode),
        .clr_cnt (clr_cnt),
        .c_out   (c_out_a),
        .toggles (toggles_a),
        .stuck   (stuck_a)
    );

    muller_c_bank #(
        .CHANNELS (4),
        .INPUTS   (4)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vec  (in_b),
        .mode    (mode),
        .clr_cnt (clr_cnt),
        .c_out   (c_out_b),
        .toggles (toggles_b),
        .stuck   (stuck_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        mode    = 2'd0;
        clr_cnt = 1'b0;
        in_a    = '0;
        in_b    = '0;

        // Reset with INIT=1, inputs low
        step(2);
        check("rst_cout_a", 32'(c_out_a), 32'hF);
        check("rst_tog_a", 32'(toggles_a), 32'h0);
        check("rst_stuck_a", 32'(stuck_a), 32'h0);
        check("rst_cout_b", 32'(c_out_b), 32'h0);
        rst_n = 1'b1;
        step(2);
        check("rel_hold_a", 32'(c_out_a), 32'hF);
        step(1);
        check("rel_cout_a", 32'(c_out_a), 32'h0);
        check("rel_tog_a", 32'(toggles_a), 32'h55);
        check("rel_tog_b", toggles_b, 32'h0);

        // SYM on ch0
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        check("clr_tog_a", 32'(toggles_a), 32'h0);
        in_a[2:0] = 3'b111;
        step(2);
        check("sym_lat", 32'(c_out_a[0]), 32'h0);
        step(1);
        check("sym_set", 32'(c_out_a[0]), 32'h1);
        in_a[2:0] = 3'b101;
        step(6);
        check("sym_hold", 32'(c_out_a[0]), 32'h1);
        in_a[2:0] = 3'b000;
        step(3);
        check("sym_rst", 32'(c_out_a[0]), 32'h0);
        check("sym_tog", 32'(toggles_a[1:0]), 32'h2);
        check("sym_stuck", 32'(stuck_a[0]), 32'h0);

        // MAJ on 4-input bank ch1
        mode = 2'd1;
        in_b[7:4] = 4'b0011;
        step(4);
        check("maj_tie0", 32'(c_out_b[1]), 32'h0);
        in_b[7:4] = 4'b0111;
        step(2);
        check("maj_lat", 32'(c_out_b[1]), 32'h0);
        step(1);
        check("maj_set", 32'(c_out_b[1]), 32'h1);
        in_b[7:4] = 4'b0011;
        step(4);
        check("maj_tie1", 32'(c_out_b[1]), 32'h1);
        in_b[7:4] = 4'b0001;
        step(3);
        check("maj_rst", 32'(c_out_b[1]), 32'h0);
        check("maj_tog", toggles_b[15:8], 32'h2);

        // ASYM on ch2
        mode = 2'd2;
        in_a[8:6] = 3'b111;
        step(3);
        check("asym_set", 32'(c_out_a[2]), 32'h1);
        in_a[8:6] = 3'b110;
        step(3);
        check("asym_rst", 32'(c_out_a[2]), 32'h0);
        in_a[8:6] = 3'b011;
        step(3);
        check("asym_hold", 32'(c_out_a[2]), 32'h0);
        in_a[8:6] = 3'b000;
        mode = 2'd0;
        step(3);

        // Watchdog on ch3, TIMEOUT=4
        in_a[11:9] = 3'b010;
        step(5);
        check("wd_early", 32'(stuck_a[3]), 32'h0);
        step(1);
        check("wd_set", 32'(stuck_a[3]), 32'h1);
        check("wd_cout", 32'(c_out_a[3]), 32'h0);
        in_a[11:9] = 3'b000;
        step(2);
        check("wd_hold", 32'(stuck_a[3]), 32'h1);
        step(1);
        check("wd_clr", 32'(stuck_a[3]), 32'h0);

        // Counter saturation on ch0, CNT_W=2
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_a[2:0] = (k % 2 == 1) ? 3'b111 : 3'b000;
            step(3);
            if (k == 1) check("sat_t1", 32'(toggles_a[1:0]), 32'h1);
            if (k == 4) check("sat_t4", 32'(toggles_a[1:0]), 32'h3);
        end
        check("sat_t5", 32'(toggles_a[1:0]), 32'h3);
        check("sat_cout", 32'(c_out_a[0]), 32'h1);
        in_a[2:0] = 3'b000;
        step(2);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        check("clr_win_cout", 32'(c_out_a[0]), 32'h0);
        check("clr_win_tog", 32'(toggles_a[1:0]), 32'h0);
        step(1);
        check("clr_after", 32'(toggles_a[1:0]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
